// File: rtl/float_pkg.sv
// float_pkg: shared class encodings, exponent constants and FSM states for float_compose
package float_pkg;
  localparam logic [4:0] CLS_ZERO = 5'b00001;
  localparam logic [4:0] CLS_NORM = 5'b00010;
  localparam logic [4:0] CLS_SUB  = 5'b00100;
  localparam logic [4:0] CLS_INF  = 5'b01000;
  localparam logic [4:0] CLS_NAN  = 5'b10000;
  localparam int EXP_BIAS = 127;
  localparam logic [7:0] EXP_ALL1 = 8'hFF;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
endpackage

// File: rtl/float_norm_shifter.sv
// float_norm_shifter: serial left-normaliser, one bit per cycle until the msb is set
module float_norm_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        clear,
  input  logic [31:0] payload,
  output logic [31:0] sr,
  output logic [4:0]  cnt,
  output logic        done
);
  assign done = sr[31];
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      sr  <= payload;
      cnt <= '0;
    end else if (step && !sr[31]) begin
      sr  <= sr << 1;
      cnt <= cnt + 5'd1;
    end
  end
endmodule

// File: rtl/float_compose.sv
// float_compose: builds a binary32 word from a one-hot class, sign and payload (FLOATCOMPOSE_RNE_EN: round-to-nearest-even on the normal path)
module float_compose
  import float_pkg::*;
#(
  parameter logic [22:0] QNAN_MANT = 23'h400000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_type,
  input  logic        in_sign,
  input  logic [31:0] in_payload,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_float,
  output logic        out_error
);
  state_t state, state_nx;
  logic [4:0] type_q;
  logic sign_q;
  logic [31:0] pay_q;
  logic [31:0] sr;
  logic [4:0] cnt;
  logic done, first, norm_ok, onehot, load, step, compose, err;
  logic [7:0] norm_exp;
  logic [30:0] norm_mag;
  logic [31:0] res;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  float_norm_shifter u_shift (
    .clk(clk), .reset(reset), .load(load), .step(step), .clear(compose),
    .payload(pay_q), .sr(sr), .cnt(cnt), .done(done)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      type_q <= '0;
      sign_q <= 1'b0;
      pay_q  <= '0;
    end else if (in_valid && in_ready) begin
      type_q <= in_type;
      sign_q <= in_sign;
      pay_q  <= in_payload;
    end
  end
  // An empty shifter in NORM marks the first cycle after accept, where the class is decided
  always_comb begin
    onehot   = (type_q != 5'd0) && ((type_q & (type_q - 5'd1)) == 5'd0);
    norm_ok  = (type_q == CLS_NORM) && (pay_q != 32'd0);
    first    = (state == NORM) && (sr == 32'd0);
    load     = first && norm_ok;
    step     = (state == NORM) && (sr != 32'd0) && !done;
    compose  = (first && !norm_ok) || ((state == NORM) && done);
    err      = !onehot || ((type_q == CLS_NORM) && (pay_q == 32'd0)) ||
               ((type_q == CLS_SUB) && (pay_q[22:0] == 23'd0));
    norm_exp = 8'(EXP_BIAS + 31) - {3'b0, cnt};
`ifdef FLOATCOMPOSE_RNE_EN
    norm_mag = {norm_exp, sr[30:8]} + {30'd0, sr[7] & ((|sr[6:0]) | sr[8])};
`else
    norm_mag = {norm_exp, sr[30:8]};
`endif
    res = err                  ? 32'h0 :
          (type_q == CLS_ZERO) ? {sign_q, 31'b0} :
          (type_q == CLS_INF)  ? {sign_q, EXP_ALL1, 23'b0} :
          (type_q == CLS_SUB)  ? {sign_q, 8'h00, pay_q[22:0]} :
          (type_q == CLS_NAN)  ? {sign_q, EXP_ALL1, (pay_q[22:0] != 23'd0) ? pay_q[22:0] : QNAN_MANT} :
                                 {sign_q, norm_mag};
  end
`ifndef FLOATCOMPOSE_RNE_EN
  logic unused_lsb;
  assign unused_lsb = ^sr[7:0];
`endif
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE && in_valid) state_nx = NORM;
    if (state == NORM && compose) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_float <= '0;
      out_error <= 1'b0;
    end else if (compose) begin
      out_float <= res;
      out_error <= err;
    end
  end
endmodule

// File: tb/tb_float_compose.sv
// tb_float_compose: directed self-checking bench for float_compose
module tb_float_compose;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, in_sign, out_valid, out_ready, out_error;
  logic [4:0] in_type;
  logic [31:0] in_payload, out_float;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  float_compose dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_sign(in_sign), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready), .out_float(out_float), .out_error(out_error)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic req(input string tag, input logic [4:0] ty, input logic s, input logic [31:0] p,
                     input logic [31:0] ef, input logic ee, input int el, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_type = ty; in_sign = s; in_payload = p;
    @(posedge clk); #1;
    in_valid = 1'b0; in_type = 5'd0; in_sign = 1'b0; in_payload = 32'd0;
    n = 0;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, " latency"}, 32'(n), 32'(el));
    chk({tag, " float"}, out_float, ef);
    chk({tag, " error"}, 32'(out_error), 32'(ee));
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, " hold float"}, out_float, ef);
      chk({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " released"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    int seen;
    reset = 1'b1; in_valid = 1'b0; in_type = 5'd0; in_sign = 1'b0; in_payload = 32'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst out_float", out_float, 32'h0);
    chk("rst out_error", 32'(out_error), 32'd0);
    req("norm1", 5'b00010, 1'b0, 32'd1, 32'h3F800000, 1'b0, 33, 0);
    req("norm5", 5'b00010, 1'b0, 32'd5, 32'h40A00000, 1'b0, 31, 0);
    req("norm5neg", 5'b00010, 1'b1, 32'd5, 32'hC0A00000, 1'b0, 31, 0);
`ifdef FLOATCOMPOSE_RNE_EN
    req("normmax", 5'b00010, 1'b0, 32'hFFFFFFFF, 32'h4F800000, 1'b0, 2, 0);
`else
    req("normmax", 5'b00010, 1'b0, 32'hFFFFFFFF, 32'h4F7FFFFF, 1'b0, 2, 0);
`endif
    req("inf", 5'b01000, 1'b1, 32'h12345678, 32'hFF800000, 1'b0, 1, 0);
    req("nan0", 5'b10000, 1'b0, 32'd0, 32'h7FC00000, 1'b0, 1, 0);
    req("nanpay", 5'b10000, 1'b1, 32'hFF800123, 32'hFF800123, 1'b0, 1, 0);
    req("sub1", 5'b00100, 1'b0, 32'd1, 32'h00000001, 1'b0, 1, 0);
    req("zero", 5'b00001, 1'b1, 32'hDEADBEEF, 32'h80000000, 1'b0, 1, 0);
    req("err2hot", 5'b00011, 1'b1, 32'd7, 32'h0, 1'b1, 1, 0);
    req("errnone", 5'b00000, 1'b0, 32'd7, 32'h0, 1'b1, 1, 0);
    req("errsub0", 5'b00100, 1'b1, 32'hFF800000, 32'h0, 1'b1, 1, 0);
    req("errnorm0", 5'b00010, 1'b0, 32'd0, 32'h0, 1'b1, 1, 0);
    req("hold", 5'b01000, 1'b0, 32'd0, 32'h7F800000, 1'b0, 1, 3);
    req("after_hold", 5'b00100, 1'b1, 32'h7FFFFF, 32'h807FFFFF, 1'b0, 1, 0);
    in_valid = 1'b1; in_type = 5'b00010; in_sign = 1'b0; in_payload = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_type = 5'd0; in_payload = 32'd0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst out_float", out_float, 32'h0);
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (out_valid) seen++; end
    chk("midrst no out_valid", 32'(seen), 32'd0);
    req("post_rst_zero", 5'b00001, 1'b0, 32'd9, 32'h00000000, 1'b0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/float_compose.md
Name: float_compose

Overview:
- Inverse of the single-precision class decoder.
- Takes a one-hot class request (zero / normal / subnormal / infinity / NaN), a sign and a payload, and builds the IEEE-754 binary32 word of that class.
- For the normal class the payload is a 32-bit unsigned integer, normalised serially one bit per cycle.
- Sits beside the classifier in the float test datapath; valid/ready on both sides.

Parameters:
QNAN_MANT, 23'h400000, mantissa used for NaN when payload[22:0] is zero

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_type  input  5  one-hot class: [0] zero, [1] normal, [2] subnormal, [3] inf, [4] NaN
in_sign  input  1  sign bit of result
in_payload  input  32  class-dependent payload
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_float  output  32  composed binary32 word
out_error  output  1  request rejected; out_float is 32'h0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on `reset`.
- States: IDLE, NORM, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Reset (any state, including mid-NORM): state=IDLE, out_float=0, out_error=0, shift register=0, shift count=0. Any in-flight request is dropped.
- Accept: an input handshake (in_valid & in_ready) at edge t latches type, sign and payload.
- Class handling:
  - Normal class goes to NORM.
  - All other classes compose directly and go to DONE; out_valid is visible after edge t+1.
- Zero: out_float = {sign, 31'b0}. Payload is ignored.
- Inf: out_float = {sign, 8'hFF, 23'b0}. Payload is ignored.
- Subnormal: out_float = {sign, 8'h00, payload[22:0]}. If payload[22:0]==0, set error.
- NaN: out_float = {sign, 8'hFF, m}, where m = payload[22:0] if nonzero, else QNAN_MANT.
- Normal:
  - payload==0 means error; go straight to DONE without entering NORM.
  - Otherwise load the 32-bit shift register and set cnt=0.
  - Each NORM cycle: if sr[31]==0, shift sr left 1 and increment cnt (5-bit counter).
  - If sr[31]==1 in a NORM cycle: compose {sign, 8'(158-cnt), sr[30:8]} and go to DONE.
  - Truncation is round-toward-zero.
  - Latency: out_valid is visible after edge t+2+cnt_final. Maximum is t+33 (payload=1).
- Error cases: out_float=32'h0 and out_error=1. Triggers:
  - in_type not exactly one-hot (zero bits set or several bits set);
  - zero normal payload;
  - zero subnormal mantissa.
- DONE:
  - out_float and out_error are held stable while out_valid & !out_ready.
  - On out_ready, go to IDLE.
  - The next request can be accepted one cycle after the output handshake; there is no same-cycle pass-through.
- Exponent range: 127..158 only, so overflow to inf is impossible.

Optional Feature:
FLOATCOMPOSE_RNE_EN
- Defined: round-to-nearest-even on the normal path.
  - guard = sr[7]; sticky = |sr[6:0]; lsb = sr[8].
  - Increment the mantissa if guard & (sticky | lsb).
  - A mantissa carry-out zeroes the mantissa and increments the exponent (max 159).
  - Rounding is done in the compose cycle; no extra latency.
- Undefined: truncation as above.

Decomposition:
- Package float_pkg holds:
  - one-hot class constants CLS_ZERO=5'b00001, CLS_NORM=5'b00010, CLS_SUB=5'b00100, CLS_INF=5'b01000, CLS_NAN=5'b10000;
  - EXP_BIAS=127;
  - EXP_ALL1=8'hFF;
  - state enum.
- One sub-module is natural: float_norm_shifter, holding the shift register, counter and the done flag.

Test Plan:
- Normal, payload=1, sign=0 -> 0x3F800000. out_valid is visible after edge t+33.
- Normal, payload=5 -> 0x40A00000. Normal, payload=0xFFFFFFFF -> 0x4F7FFFFF without RNE, 0x4F800000 with FLOATCOMPOSE_RNE_EN.
- Inf, sign=1 -> 0xFF800000. NaN, payload=0 -> 0x7FC00000. Subnormal, payload=1 -> 0x00000001. Zero, sign=1 -> 0x80000000. Each non-normal case: out_valid visible after edge t+1.
- in_type=5'b00011, or subnormal with payload=0, or normal with payload=0 -> out_error=1, out_float=0.
- out_ready held low 3 cycles after out_valid -> out_float stable, in_ready=0. Release -> IDLE next edge, and a new request is accepted.
- reset pulsed in NORM, 10 cycles after accepting payload=1 -> IDLE next edge. No out_valid appears. A following zero request completes normally.
